// File: rtl/beam_thresh_loader_pkg.sv
// Shared types and constants for the beamformer threshold loader.
package pueo_thresh_pkg;

    localparam int THRESH_BITS = 18;
    localparam int NSETS       = 2;

    typedef logic [THRESH_BITS-1:0] thresh_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP   = 3'd1,
        LOAD   = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } thresh_ld_state_t;

    // Zero a threshold word when its set is not part of the current load.
    function automatic thresh_t mask_set(thresh_t v, logic en);
        return en ? v : '0;
    endfunction

endpackage

// File: rtl/beam_thresh_loader_if.sv
// Host/config bus plus cascade outputs of the threshold loader.
// cfg_rdata_o exists only when THRESH_READBACK_EN is defined.
interface beam_thresh_loader_if
    import pueo_thresh_pkg::*;
#(
    parameter int NBEAMS = 2
);
    localparam int ADDR_W = $clog2(2*NBEAMS);

    logic [ADDR_W-1:0]        cfg_addr_i;
    thresh_t                  cfg_data_i;
    logic                     cfg_wr_i;
    logic [NSETS-1:0]         commit_i;
    logic                     busy_o;
    logic                     done_o;
    logic [NSETS*THRESH_BITS-1:0] thresh_o;
    logic [NSETS-1:0]         thresh_wr_o;
    logic [NSETS-1:0]         thresh_update_o;
`ifdef THRESH_READBACK_EN
    thresh_t                  cfg_rdata_o;
`endif

    modport master (
        output cfg_addr_i, cfg_data_i, cfg_wr_i, commit_i,
`ifdef THRESH_READBACK_EN
        input  cfg_rdata_o,
`endif
        input  busy_o, done_o, thresh_o, thresh_wr_o, thresh_update_o
    );

    modport slave (
        input  cfg_addr_i, cfg_data_i, cfg_wr_i, commit_i,
`ifdef THRESH_READBACK_EN
        output cfg_rdata_o,
`endif
        output busy_o, done_o, thresh_o, thresh_wr_o, thresh_update_o
    );

endinterface

// File: rtl/thresh_shadow_ram.sv
// Shadow copy of all beam thresholds: one write port, one streaming read
// port returning both sets of a beam (masked per set), and an optional
// host readback port under THRESH_READBACK_EN.
module thresh_shadow_ram
    import pueo_thresh_pkg::*;
#(
    parameter int NBEAMS = 2,
    localparam int ADDR_W = $clog2(2*NBEAMS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wr_en_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  thresh_t                      wr_data_i,
    input  logic                         rd_en_i,
    input  logic [ADDR_W-1:0]            rd_beam_i,
    input  logic [NSETS-1:0]             rd_mask_i,
    output logic [NSETS*THRESH_BITS-1:0] rd_data_o
`ifdef THRESH_READBACK_EN
    ,
    input  logic [ADDR_W-1:0]            rb_addr_i,
    output thresh_t                      rb_data_o
`endif
);
    localparam int DEPTH = 2*NBEAMS;

    // Contents are not touched by reset so thresholds survive a soft reset.
    thresh_t mem [DEPTH];

    logic [ADDR_W-1:0] a0, a1;
    assign a0 = rd_beam_i << 1;
    assign a1 = a0 | ADDR_W'(1);

    // Shadow write port; caller has already range-checked the address.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    end

    // Streaming read: registered, masked pair; zero whenever not reading.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)      rd_data_o <= '0;
        else if (rd_en_i) rd_data_o <= {mask_set(mem[a1], rd_mask_i[1]),
                                        mask_set(mem[a0], rd_mask_i[0])};
        else              rd_data_o <= '0;
    end

`ifdef THRESH_READBACK_EN
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    // Host readback, independent of the loader; out-of-range reads as zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)                          rb_data_o <= '0;
        else if ({1'b0, rb_addr_i} < DEPTH_C) rb_data_o <= mem[rb_addr_i];
        else                                  rb_data_o <= '0;
    end
`endif

endmodule

// File: rtl/beam_thresh_loader.sv
// Streams shadowed beam thresholds into the DSP threshold cascade
// (last beam first, head beam last) then pulses the per-set latch.
// Optional: THRESH_READBACK_EN adds host readback of the shadow.
module beam_thresh_loader
    import pueo_thresh_pkg::*;
#(
    parameter int NBEAMS = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    beam_thresh_loader_if.slave  bus
);
    localparam int ADDR_W = $clog2(2*NBEAMS);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(2*NBEAMS);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(NBEAMS-1);

    thresh_ld_state_t  state_q;
    logic [NSETS-1:0]  pend_q, act_q, wr_q, upd_q;
    logic [ADDR_W-1:0] cnt_q, rd_beam;
    logic              busy_q, done_q, start, rd_en, wr_ok;

    assign start = (state_q == IDLE) && (pend_q != '0);
    // PREP prefetches the last beam; LOAD prefetches the beam after the one on the bus.
    assign rd_en   = (state_q == PREP) || ((state_q == LOAD) && (cnt_q != '0));
    assign rd_beam = (state_q == PREP) ? LAST_C : cnt_q - 1'b1;
    assign wr_ok   = bus.cfg_wr_i && !busy_q && ({1'b0, bus.cfg_addr_i} < DEPTH_C);

    thresh_shadow_ram #(.NBEAMS(NBEAMS)) u_shadow (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (wr_ok),
        .wr_addr_i (bus.cfg_addr_i),
        .wr_data_i (bus.cfg_data_i),
        .rd_en_i   (rd_en),
        .rd_beam_i (rd_beam),
        .rd_mask_i (act_q),
        .rd_data_o (bus.thresh_o)
`ifdef THRESH_READBACK_EN
        ,
        .rb_addr_i (bus.cfg_addr_i),
        .rb_data_o (bus.cfg_rdata_o)
`endif
    );

    // Load sequencer: pending-commit capture, state walk and strobe registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q  <= '0;
            act_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= '0;
            upd_q   <= '0;
        end else begin
            pend_q <= (start ? '0 : pend_q) | bus.commit_i;
            done_q <= 1'b0;
            wr_q   <= '0;
            upd_q  <= '0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= PREP;
                    act_q   <= pend_q;
                    busy_q  <= 1'b1;
                end
                PREP: begin
                    state_q <= LOAD;
                    cnt_q   <= LAST_C;
                    wr_q    <= act_q;
                end
                LOAD: if (cnt_q == '0) begin
                    state_q <= UPDATE;
                    upd_q   <= act_q;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                    wr_q  <= act_q;
                end
                UPDATE: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy_o          = busy_q;
    assign bus.done_o          = done_q;
    assign bus.thresh_wr_o     = wr_q;
    assign bus.thresh_update_o = upd_q;

endmodule

// File: doc/beam_thresh_loader.md
# beam_thresh_loader

Initiator for the beamformer threshold-cascade protocol. Holds a host-writable shadow copy of every beam's two 18-bit thresholds. On command it streams them into the DSP threshold cascade (`thresh_o` / `thresh_wr_o`) and then issues the `thresh_update_o` latch pulse. Sits between the register bank and the beamform trigger, on the trigger clock.

## Interface
Parameters
- NBEAMS, 2: beams on the cascade; range 1..48. Odd values are legal and still need one write per beam.
- ADDR_W, $clog2(2*NBEAMS) (localparam): shadow address width.

Ports
- clk_i  in  1  trigger clock.
- rst_ni  in  1  reset, synchronous, active-low.
- cfg_addr_i  in  ADDR_W  shadow address = beam*2 + set.
- cfg_data_i  in  18  threshold value.
- cfg_wr_i  in  1  shadow write strobe.
- commit_i  in  2  per-set load request, single-cycle pulse.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse at end of each load.
- thresh_o  out  36  {set1[17:0], set0[17:0]}.
- thresh_wr_o  out  2  per-set cascade shift strobe.
- thresh_update_o  out  2  per-set cascade latch strobe.
- cfg_rdata_o  out  18  shadow readback; present only with THRESH_READBACK_EN.

## Operation
- Shadow: 2*NBEAMS x 18 bits. Initialised to 0 at configuration and not cleared by rst_ni.
- Shadow writes are accepted only when busy_o=0. Writes while busy, or to addresses >= 2*NBEAMS, are dropped silently.
- Pending mask `pend[1:0]`: ORs in commit_i every cycle. The active mask `act` is copied from pend when a load starts, and pend is cleared in the same cycle.
- FSM states:
  - IDLE: if pend != 0, go to PREP.
  - PREP: issue shadow read for beam NBEAMS-1; go to LOAD.
  - LOAD: NBEAMS cycles; beam index counts down NBEAMS-1..0. On the last count, go to UPDATE.
  - UPDATE: one cycle; go to DONE.
  - DONE: one cycle; go to IDLE.
- Order: the first word written lands at beam NBEAMS-1 and the last at beam 0, which is the non-cascaded head.
- In LOAD, `thresh_wr_o = act`. `thresh_o` set s carries the shadow value if act[s], else 0.
- In UPDATE, `thresh_update_o = act` and `thresh_o = 0`.
- In DONE, `done_o = 1`. If pend != 0 (commits made during the load), the FSM re-enters PREP from IDLE on the next cycle.
- Outputs for a set not in act stay 0 for the whole load.

## Timing
- All outputs are registered.
- Reset values: busy_o=0, done_o=0, thresh_o=0, thresh_wr_o=0, thresh_update_o=0, cfg_rdata_o=0.
- Commit sampled at edge E0 (IDLE, pend was 0):
  - busy_o=1 from E1.
  - thresh_wr_o high for the cycles following edges E2..E(NBEAMS+1).
  - thresh_update_o high after E(NBEAMS+2).
  - done_o high and busy_o=0 after E(NBEAMS+3).
- Write strobes within one load are consecutive with no gaps.
- Shadow read latency is 1 cycle. A write and a read to the same address in one cycle cannot occur, because writes are blocked while busy.
- commit_i arriving in the same cycle as done_o is captured in pend, and the next load starts 2 cycles later.
- rst_ni low mid-load: next edge forces IDLE, clears pend and act, zeroes outputs. No update pulse is issued, so the cascade may hold partial shifted data that is not latched.

## Configuration
- THRESH_READBACK_EN defined: `cfg_rdata_o` is the registered shadow[cfg_addr_i], valid 1 cycle after the address. Out-of-range addresses return 0. Readback reads are allowed while busy.
- THRESH_READBACK_EN undefined: the port is absent and the shadow has a single read port.

## Structure
- Package `pueo_thresh_pkg`: THRESH_BITS=18, NSETS=2, state enum `thresh_ld_state_t` {IDLE, PREP, LOAD, UPDATE, DONE}.
- Sub-module `thresh_shadow_ram`: 2*NBEAMS x 18 distributed RAM, one write port and one streaming read port, plus the readback port under THRESH_READBACK_EN.

## Test plan
- NBEAMS=2. Write addr0=0x00100, addr1=0x00200, addr2=0x00300, addr3=0x00400; commit_i=2'b11 → two cycles with thresh_wr_o=11. thresh_o={0x00400,0x00300} then {0x00200,0x00100}. Next cycle thresh_update_o=11, then done_o; 5 cycles from commit edge to done.
- commit_i=2'b01 only → thresh_wr_o=01 and thresh_update_o=01; thresh_o[35:18]=0 throughout.
- Pulse commit_i=2'b10 during LOAD of a 2'b01 load → second load with act=10 starts 2 cycles after done_o.
- cfg_wr_i to addr0 with 0x3FFFF while busy → shadow unchanged; the next load streams the old value.
- rst_ni low on the first LOAD cycle → all outputs 0 next cycle, no thresh_update_o, busy_o=0. The shadow is retained, and a fresh commit streams the original values.
- THRESH_READBACK_EN, NBEAMS=3: read addr5 after writing 0x12345 → 0x12345 one cycle later. Read addr6 → 0.
